muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine beside the EX-stage ALU. Executes LoongArch MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU.
- Holds the pipeline with `stall` while busy. Presents a registered result with a one-cycle `done` pulse, after which the EX instruction advances.
- The multiply path uses a pipelined multiplier. The divide path uses a 32-step restoring divider on operand magnitudes, with sign fix-up at the end.

---
 rtl/muldiv_unit_pkg.sv | 58 +++++
 rtl/muldiv_unit_if.sv | 46 ++++
 rtl/muldiv_unit_mul_pipe.sv | 57 +++++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - WORD          : datapath width (only 32 is supported)
//   - md_op_e       : 3-bit operation encodings (MD_MUL_W .. MD_MOD_WU)
//   - md_state_e    : 3-bit FSM state encodings (MD_IDLE .. MD_DONE)
//   - helper functions for op decoding and operand magnitude
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam int WORD = 32;

  typedef enum logic [2:0] {
    MD_MUL_W   = 3'b000,
    MD_MULH_W  = 3'b001,
    MD_MULH_WU = 3'b010,
    MD_RSVD    = 3'b011,  // reserved, executes as MD_MUL_W
    MD_DIV_W   = 3'b100,
    MD_MOD_W   = 3'b101,
    MD_DIV_WU  = 3'b110,
    MD_MOD_WU  = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // Bit 2 of the op code separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // DIV_W / MOD_W are the signed divides (bit 1 clear within the divide family).
  function automatic logic op_is_signed_div(input logic [2:0] op);
    return op[2] & ~op[1];
  endfunction

  // Only MULH_WU treats its operands as unsigned; reserved 011 behaves as MUL_W.
  function automatic logic op_is_signed_mul(input logic [2:0] op);
    return (op != MD_MULH_WU);
  endfunction

  // Low half of the product is returned only for MUL_W and the reserved code.
  function automatic logic op_is_mul_lo(input logic [2:0] op);
    return (op == MD_MUL_W) || (op == MD_RSVD);
  endfunction

  // Magnitude of x when treated as signed; raw value otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] x, input logic is_signed);
    return (is_signed && x[WORD-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the EX stage (master) and muldiv_unit (slave).
//
// Handshake: the EX stage holds `start` high, with op/src_a/src_b stable, for as
// long as the instruction sits in EX. `stall` (combinational) holds the pipeline
// while the unit works. `done` is a one-cycle pulse with `result` valid in the
// same cycle; the EX instruction advances on that cycle and the next start may
// be presented from the following cycle. `flush` kills the instruction in EX at
// any time and has priority over start.
//
// Signals:
//   start  EX->unit  level request
//   op     EX->unit  operation select (md_op_e encoding)
//   src_a  EX->unit  rj operand
//   src_b  EX->unit  rk operand
//   flush  EX->unit  kill the EX instruction
//   stall  unit->EX  start & ~done & ~flush
//   busy   unit->EX  unit not idle
//   done   unit->EX  one-cycle completion pulse
//   result unit->EX  registered result, held until the next done
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [WORD-1:0] src_a;
  logic [WORD-1:0] src_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [WORD-1:0] result;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/muldiv_unit_mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe
// MUL_LATENCY-stage 32x32->64 multiplier. Operands are sign- or zero-extended
// to 64 bits at the input according to signed_i, multiplied, and pushed through
// a register chain. The first stage samples the operands directly, so the
// product of operands presented in cycle t appears on prod_o in cycle
// t+MUL_LATENCY.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   a_i, b_i  32-bit operands
//   signed_i  1: signed product, 0: unsigned product
//   prod_o    64-bit product from the last register stage
// -----------------------------------------------------------------------------
module mul_pipe
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD-1:0]   a_i,
  input  logic [WORD-1:0]   b_i,
  input  logic              signed_i,
  output logic [2*WORD-1:0] prod_o
);

  logic [2*WORD-1:0] a_ext;
  logic [2*WORD-1:0] b_ext;
  logic [2*WORD-1:0] prod_c;
  logic [2*WORD-1:0] stage_q [MUL_LATENCY];

  // A 64x64 product truncated to 64 bits equals the exact 32x32 product once
  // both operands are extended the right way, so one multiplier covers both.
  always_comb begin
    a_ext  = {{WORD{signed_i & a_i[WORD-1]}}, a_i};
    b_ext  = {{WORD{signed_i & b_i[WORD-1]}}, b_i};
    prod_c = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= prod_c;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign prod_o = stage_q[MUL_LATENCY-1];

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle multiply/divide engine beside the EX-stage ALU. Executes MUL.W,
// MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU. Multiplies use the
// pipelined mul_pipe (done at t+MUL_LATENCY+1); divides use a 32-step restoring
// divider on operand magnitudes followed by a sign fix-up (done at t+34).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   bus          muldiv_unit_if.slave (start/op/src_a/src_b/flush in,
//                stall/busy/done/result out)
//   dbg_state_o  current FSM state, for observation only
//
// Build option:
//   MULDIV_DIV_EARLY_OUT_EN - when defined, a divide with b = 0 or |a| < |b|
//   skips the iterative phase and goes straight to FIX (done at t+2).
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2   // 1..4
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_unit_if.slave       bus,
  output md_state_e          dbg_state_o
);

  md_state_e         state_q;
  logic [2:0]        op_q;
  logic [4:0]        cnt_q;
  logic [WORD-1:0]   rem_q;
  logic [WORD-1:0]   quo_q;
  logic [WORD-1:0]   mag_b_q;
  logic              sign_q_q;
  logic              sign_r_q;
  logic              done_q;
  logic [WORD-1:0]   result_q;

  logic [2*WORD-1:0] prod;

  // Accept-time decode of the incoming request.
  logic              in_signed_div;
  logic              in_b_zero;
  logic [WORD-1:0]   in_mag_a;
  logic [WORD-1:0]   in_mag_b;

  // One restoring step and the final fix-up.
  logic [WORD:0]     shifted;
  logic              trial_ge;
  logic [WORD-1:0]   rem_d;
  logic [WORD-1:0]   quo_d;
  logic [WORD-1:0]   quo_fix;
  logic [WORD-1:0]   rem_fix;

  mul_pipe #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_pipe (
    .clk      (clk),
    .rst      (rst),
    .a_i      (bus.src_a),
    .b_i      (bus.src_b),
    .signed_i (op_is_signed_mul(bus.op)),
    .prod_o   (prod)
  );

  always_comb begin
    in_signed_div = op_is_signed_div(bus.op);
    in_b_zero     = (bus.src_b == '0);
    in_mag_a      = mag(bus.src_a, in_signed_div);
    in_mag_b      = mag(bus.src_b, in_signed_div);

    // {rem, quo} shifted left one bit; the extra top bit keeps the trial
    // subtraction exact because the partial remainder can reach 2*|b|-1.
    shifted  = {rem_q, quo_q[WORD-1]};
    trial_ge = (shifted >= {1'b0, mag_b_q});
    rem_d    = trial_ge ? WORD'(shifted - {1'b0, mag_b_q}) : shifted[WORD-1:0];
    quo_d    = {quo_q[WORD-2:0], trial_ge};

    quo_fix  = sign_q_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = sign_r_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mag_b_q  <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        // Kill wins over everything; result keeps its previous value.
        state_q <= MD_IDLE;
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (bus.start) begin
              op_q <= bus.op;
              if (op_is_div(bus.op)) begin
                mag_b_q  <= in_mag_b;
                // Divide by zero must leave the all-ones quotient untouched.
                sign_q_q <= in_signed_div & (bus.src_a[WORD-1] ^ bus.src_b[WORD-1])
                            & ~in_b_zero;
                sign_r_q <= in_signed_div & bus.src_a[WORD-1];
`ifdef MULDIV_DIV_EARLY_OUT_EN
                if (in_b_zero || (in_mag_a < in_mag_b)) begin
                  quo_q   <= in_b_zero ? '1 : '0;
                  rem_q   <= in_mag_a;
                  state_q <= MD_FIX;
                end else begin
                  quo_q   <= in_mag_a;
                  rem_q   <= '0;
                  cnt_q   <= 5'd31;
                  state_q <= MD_DIV;
                end
`else
                quo_q   <= in_mag_a;
                rem_q   <= '0;
                cnt_q   <= 5'd31;
                state_q <= MD_DIV;
`endif
              end else begin
                cnt_q   <= 5'(MUL_LATENCY - 1);
                state_q <= MD_MUL;
              end
            end
          end

          MD_MUL: begin
            if (cnt_q == '0) begin
              result_q <= op_is_mul_lo(op_q) ? prod[WORD-1:0] : prod[2*WORD-1:WORD];
              done_q   <= 1'b1;
              state_q  <= MD_DONE;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end

          MD_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
              state_q <= MD_FIX;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end

          MD_FIX: begin
            // op bit 0 distinguishes MOD (remainder) from DIV (quotient).
            result_q <= op_q[0] ? rem_fix : quo_fix;
            done_q   <= 1'b1;
            state_q  <= MD_DONE;
          end

          MD_DONE: begin
            // start still belongs to the finishing instruction here.
            state_q <= MD_IDLE;
          end

          default: state_q <= MD_IDLE;
        endcase
      end
    end
  end

  assign bus.stall   = bus.start & ~done_q & ~bus.flush;
  assign bus.busy    = (state_q != MD_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int ML      = 2;
  localparam int MUL_LAT = ML + 1;
  localparam int DIV_LAT = 34;
`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam int EO_LAT  = 2;
`else
  localparam int EO_LAT  = 34;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  md_state_e     dbg_state;

  muldiv_unit #(
    .MUL_LATENCY (ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_res = '0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for done with stall checked every busy cycle; bounded at 100 cycles.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      check({tag, "_stall"}, 32'(bus.stall), 32'd1);
      @(negedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    #1;
    wait_done(tag, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    last_res  = exp;
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_result", bus.result, 32'h0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_state",  32'(dbg_state), 32'(MD_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // multiplies
    run_op("mul_w",      MD_MUL_W,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh_w",     MD_MULH_W,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
    run_op("mulh_wu",    MD_MULH_WU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT);
    run_op("mul_rsvd",   MD_RSVD,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mul_w_big",  MD_MUL_W,   32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT);

    // divides
    run_op("div_w",      MD_DIV_W,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
    run_op("mod_w",      MD_MOD_W,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
    run_op("div_w_neg",  MD_DIV_W,   32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT);
    run_op("mod_w_neg",  MD_MOD_W,   32'd100,      32'hFFFFFFF9, 32'h00000002, DIV_LAT);
    run_op("div_wu_big", MD_DIV_WU,  32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, DIV_LAT);
    run_op("div_wu_z",   MD_DIV_WU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, EO_LAT);
    run_op("mod_wu_z",   MD_MOD_WU,  32'h00000005, 32'h00000000, 32'h00000005, EO_LAT);
    run_op("div_w_z",    MD_DIV_W,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, EO_LAT);
    run_op("mod_w_z",    MD_MOD_W,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, EO_LAT);
    run_op("div_w_ovf",  MD_DIV_W,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);
    run_op("mod_w_ovf",  MD_MOD_W,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT);
    run_op("div_wu_lt",  MD_DIV_WU,  32'h00000003, 32'h00000009, 32'h00000000, EO_LAT);
    run_op("mod_wu_lt",  MD_MOD_WU,  32'h00000003, 32'h00000009, 32'h00000003, EO_LAT);

    // flush at t+10 of a long divide, then a MUL_W started at t+11
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_DIV_WU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd7;
    #1;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", 32'(bus.stall), 32'd0);
    check("flush_done",  32'(bus.done),  32'd0);
    @(negedge clk); #1;
    check("flush_state",  32'(dbg_state), 32'(MD_IDLE));
    check("flush_busy",   32'(bus.busy),  32'd0);
    check("flush_done2",  32'(bus.done),  32'd0);
    check("flush_result", bus.result,     last_res);
    bus.flush = 1'b0;
    bus.op    = MD_MUL_W;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    #1;
    wait_done("post_flush", lat);
    check("post_flush_lat", 32'(lat), 32'(MUL_LAT));
    check("post_flush_res", bus.result, 32'd42);
    bus.start = 1'b0;

    // asynchronous reset at t+5 of a divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_DIV_W;
    bus.src_a = 32'hFFFFFFF9;
    bus.src_b = 32'd2;
    #1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_result", bus.result,      32'h0);
    check("mid_rst_done",   32'(bus.done),   32'd0);
    check("mid_rst_busy",   32'(bus.busy),   32'd0);
    check("mid_rst_state",  32'(dbg_state),  32'(MD_IDLE));
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op("after_rst",  MD_MUL_W,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
